// File: rtl/rr_arb_pkg.sv
// Shared constants, FSM state type and grant helper for the 8-lane round-robin arbiter.
package rr_arb_pkg;

  localparam int N_LANES         = 8;
  localparam int SEL_W           = 3;
  localparam int TIMEOUT_DEFAULT = 15;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic logic [N_LANES-1:0] onehot8(input logic [SEL_W-1:0] idx);
    onehot8 = {{(N_LANES-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating-priority encoder: first set request after lane 'last', wrapping.
module rr_pick8
  import rr_arb_pkg::*;
(
  input  logic [N_LANES-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic [SEL_W-1:0]   pick,
  output logic               any
);

  logic [SEL_W-1:0] idx_s;

  // Scan last+1 .. last+8 (mod 8); 3-bit addition provides the wrap.
  always_comb begin
    pick  = 3'd0;
    any   = 1'b0;
    idx_s = 3'd0;
    for (int i = 1; i <= N_LANES; i++) begin
      idx_s = last + 3'(i);
      if (!any && req[idx_s]) begin
        pick = idx_s;
        any  = 1'b1;
      end else begin
        pick = pick;
      end
    end
  end

endmodule

// File: rtl/rr_arb8_ctrl.sv
// Round-robin arbiter/sequencer for the shared 8-lane select datapath.
// Optional stall timeout with item drop enabled by defining RR_ARB_TIMEOUT_EN.
module rr_arb8_ctrl
  import rr_arb_pkg::*;
#(
  parameter int W       = 4,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_LANES-1:0]   req,
  input  logic [N_LANES*W-1:0] din,
  output logic [SEL_W-1:0]     s,
  output logic [N_LANES-1:0]   gnt,
  output logic [W-1:0]         y,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic [N_LANES-1:0]   ack,
  output logic                 err
);

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     s_q, s_d;
  logic [SEL_W-1:0]     last_q, last_d;
  logic [N_LANES-1:0]   gnt_q, gnt_d;
  logic [W-1:0]         y_q, y_d;
  logic                 y_valid_q, y_valid_d;
  logic [SEL_W-1:0]     pick_s;
  logic                 any_s;
  logic                 done_s;
  logic                 timeout_s;

  rr_pick8 u_pick (
    .req  (req),
    .last (last_q),
    .pick (pick_s),
    .any  (any_s)
  );

  assign done_s = y_valid_q & y_ready;

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

  logic [3:0] wait_q, wait_d;

  // Stall counter: held at zero while idle so every grant starts from zero.
  always_comb begin
    wait_d = wait_q;
    if (state_q == IDLE) begin
      wait_d = 4'd0;
    end else if (y_valid_q & ~y_ready) begin
      wait_d = wait_q + 4'd1;
    end else begin
      wait_d = wait_q;
    end
  end

  // Drop fires in the cycle whose edge would bring the count to TIMEOUT.
  assign timeout_s = (state_q == BUSY) & y_valid_q & ~y_ready & (wait_q == WAIT_LAST);

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= 4'd0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state logic: grant in IDLE, hold the latched item in BUSY until done or drop.
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    case (state_q)
      IDLE: begin
        if (any_s) begin
          s_d       = pick_s;
          gnt_d     = onehot8(pick_s);
          y_d       = din[W*int'(pick_s) +: W];
          y_valid_d = 1'b1;
          state_d   = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (done_s | timeout_s) begin
          last_d    = s_q;
          gnt_d     = {N_LANES{1'b0}};
          y_valid_d = 1'b0;
          state_d   = IDLE;
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and capture registers; last starts at 7 so lane 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      s_q       <= 3'd0;
      last_q    <= 3'd7;
      gnt_q     <= 8'd0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign s       = s_q;
  assign gnt     = gnt_q;
  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign ack     = gnt_q & {N_LANES{done_s | timeout_s}};
  assign err     = timeout_s;

endmodule

// File: tb/tb_rr_arb8_ctrl.sv
// Scoreboard bench for rr_arb8_ctrl: expected grants queued at stimulus, checked on transfer.
module tb_rr_arb8_ctrl;

  localparam int W = 4;

  typedef struct packed {
    logic [2:0]   lane;
    logic [W-1:0] word;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [7:0]     req;
  logic [8*W-1:0] din;
  logic [2:0]     s;
  logic [7:0]     gnt;
  logic [W-1:0]   y;
  logic           y_valid;
  logic           y_ready;
  logic [7:0]     ack;
  logic           err;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  rr_arb8_ctrl #(.W(W), .TIMEOUT(15)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .din     (din),
    .s       (s),
    .gnt     (gnt),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .ack     (ack),
    .err     (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_word(input int lane, input logic [W-1:0] word);
    din[W*lane +: W] = word;
  endtask

  task automatic push(input int lane, input logic [W-1:0] word);
    exp_t e;
    e.lane = 3'(lane);
    e.word = word;
    sb.push_back(e);
  endtask

  // One clock: check at negedge, then the requester model drops acked lanes after the edge.
  task automatic step();
    logic [7:0] a;
    exp_t       e;
    @(negedge clk);
    a = ack;
    check_eq("err_quiet", 32'(err), 32'd0);
    if (y_valid && y_ready) begin
      check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("xfer_s", 32'(s), 32'(e.lane));
        check_eq("xfer_y", 32'(y), 32'(e.word));
        check_eq("xfer_gnt", 32'(gnt), 32'(8'd1 << e.lane));
        check_eq("xfer_ack", 32'(a), 32'(8'd1 << e.lane));
      end
    end else begin
      check_eq("ack_quiet", 32'(a), 32'd0);
    end
    @(posedge clk);
    #1;
    req = req & ~a;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = 8'd0;
    din     = '0;
    y_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_s", 32'(s), 32'd0);
    check_eq("rst_gnt", 32'(gnt), 32'd0);
    check_eq("rst_y", 32'(y), 32'd0);
    check_eq("rst_valid", 32'(y_valid), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_ack", 32'(ack), 32'd0);
    rst_n = 1'b1;

    // Single request, 1-cycle latency, same-cycle transfer.
    set_word(0, 4'hA);
    req     = 8'h01;
    y_ready = 1'b1;
    push(0, 4'hA);
    step();
    check_eq("t1_latency_valid", 32'(y_valid), 32'd1);
    check_eq("t1_gnt", 32'(gnt), 32'h01);
    step();
    check_eq("t1_valid_drop", 32'(y_valid), 32'd0);

    // All lanes from reset: order 0..7, one item per two cycles, then 0 again.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_word(i, 4'((i * 3 + 1) % 16));
      push(i, 4'((i * 3 + 1) % 16));
    end
    req = 8'hFF;
    repeat (16) step();
    check_eq("t2_drained", 32'(sb.size()), 32'd0);
    req = 8'h01;
    push(0, 4'h1);
    repeat (2) step();
    check_eq("t2_wrap_drained", 32'(sb.size()), 32'd0);

    // Wrap-around: last=5, lanes 0 and 5 requesting -> 0 first, then 5.
    req = 8'h20;
    push(5, 4'h0);
    repeat (2) step();
    req = 8'h21;
    push(0, 4'h1);
    push(5, 4'h0);
    repeat (4) step();
    check_eq("t3_drained", 32'(sb.size()), 32'd0);

    // Backpressure: lane 3 held while din changes.
    set_word(3, 4'h9);
    req     = 8'h08;
    y_ready = 1'b0;
    push(3, 4'h9);
    step();
    for (int k = 0; k < 4; k++) begin
      set_word(3, 4'(k + 2));
      step();
      check_eq("t4_hold_y", 32'(y), 32'h9);
      check_eq("t4_hold_gnt", 32'(gnt), 32'h08);
    end
    y_ready = 1'b1;
    repeat (2) step();
    check_eq("t4_drained", 32'(sb.size()), 32'd0);

    // Reset while BUSY clears outputs at once; priority restarts at lane 0.
    y_ready = 1'b0;
    req     = 8'h10;
    step();
    check_eq("t5_busy_valid", 32'(y_valid), 32'd1);
    check_eq("t5_busy_gnt", 32'(gnt), 32'h10);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_valid", 32'(y_valid), 32'd0);
    check_eq("t5_rst_gnt", 32'(gnt), 32'd0);
    check_eq("t5_rst_ack", 32'(ack), 32'd0);
    check_eq("t5_rst_y", 32'(y), 32'd0);
    req = 8'd0;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    req     = 8'hFF;
    y_ready = 1'b1;
    push(0, 4'h1);
    push(1, 4'h4);
    repeat (4) step();
    req = 8'd0;
    step();
    check_eq("t5_drained", 32'(sb.size()), 32'd0);

`ifdef RR_ARB_TIMEOUT_EN
    // Timeout: lane 2 stalled, dropped in the 15th valid cycle with ack and err.
    set_word(2, 4'h5);
    req     = 8'h04;
    y_ready = 1'b0;
    step();
    for (int k = 1; k <= 15; k++) begin
      logic [7:0] a;
      @(negedge clk);
      a = ack;
      check_eq("t6_valid", 32'(y_valid), 32'd1);
      check_eq("t6_err", 32'(err), (k == 15) ? 32'd1 : 32'd0);
      check_eq("t6_ack", 32'(a), (k == 15) ? 32'h04 : 32'd0);
      @(posedge clk);
      #1;
      req = req & ~a;
    end
    check_eq("t6_valid_drop", 32'(y_valid), 32'd0);
    check_eq("t6_gnt_drop", 32'(gnt), 32'd0);
    check_eq("t6_req_dropped", 32'(req), 32'd0);
`endif

    check_eq("final_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
